data_mem_access_unit: RTL and testbench

Data-memory responder for the RISC-V core. It consumes the `memory_read` / `memory_write` strobes produced by the main controller, together with the ALU byte address, `funct3` and rs2 data. It performs byte, half-word and word loads and stores against an internal word-organised RAM with a configurable number of wait states. It drives a `stall` signal back to the core and returns the sign- or zero-extended load result for the write-back mux.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/dmem_ram.sv | 37 +++
 rtl/data_mem_access_unit.sv | 217 +++++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: funct3 access-size encodings and the
// data-memory access FSM state.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } dmem_size_t;

    // Reserved encodings fall back to a word access.
    function automatic dmem_size_t f3_size(input logic [2:0] f3);
        dmem_size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            F3_W:        sz = SZ_W;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: 4 byte-write enables, synchronous write,
// registered read that only updates when i_re is high.
module dmem_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_re,
    input  logic [3:0]            i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Contents survive reset; only the output register clears.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_access_unit.sv
// Data-memory responder: sized loads/stores with WAIT_STATES latency.
// Define DMEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
import riscv_pkg::*;

module data_mem_access_unit #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned
);

    localparam int  AB       = ADDR_WIDTH + 2;
    localparam bit  HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_LOAD =
        HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t r_state, w_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic [AB-1:0] r_addr;
    logic [2:0]    r_f3;
    logic [31:0]   r_wdata;
    logic          r_store;
    logic [1:0]    r_ld_lane;
    logic [2:0]    r_ld_f3;
    logic          r_ld_zero;

    logic          w_req, w_start, w_stall;
    logic [AB-1:0] w_cur_addr;
    logic [2:0]    w_cur_f3;
    logic          w_cur_store;
    dmem_size_t    w_size, w_ld_size;
    logic [1:0]    w_lane;
    logic          w_mis;
    logic [3:0]    w_be, w_ram_be;
    logic [31:0]   w_ram_wdata, w_q;
    logic          w_ld_fire;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;
    logic          w_unused;

    assign w_unused = &{1'b0, address[31:AB]};

    assign w_req   = memory_read | memory_write;
    assign w_start = (r_state == IDLE) & w_req;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_stall    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall    = 1'b1;
                    w_next     = HAS_WAIT ? WAIT : DONE;
                    w_cnt_next = WS_LOAD;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr  <= '0;
            r_f3    <= '0;
            r_wdata <= '0;
            r_store <= 1'b0;
        end else if (w_start) begin
            r_addr  <= address[AB-1:0];
            r_f3    <= funct3;
            r_wdata <= write_data;
            r_store <= memory_write;
        end
    end

    // In IDLE the live request drives the RAM so zero-wait loads work.
    assign w_cur_addr  = (r_state == IDLE) ? address[AB-1:0] : r_addr;
    assign w_cur_f3    = (r_state == IDLE) ? funct3 : r_f3;
    assign w_cur_store = (r_state == IDLE) ? memory_write : r_store;
    assign w_size      = f3_size(w_cur_f3);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis  = ((w_size == SZ_H) & w_cur_addr[0])
                  | ((w_size == SZ_W) & (w_cur_addr[1:0] != 2'b00));
    assign w_lane = w_cur_addr[1:0];
`else
    assign w_mis  = 1'b0;
    always_comb begin
        w_lane = 2'b00;
        unique case (1'b1)
            (w_size == SZ_B): w_lane = w_cur_addr[1:0];
            (w_size == SZ_H): w_lane = {w_cur_addr[1], 1'b0};
            default:          w_lane = 2'b00;
        endcase
    end
`endif

    always_comb begin
        w_be        = 4'b1111;
        w_ram_wdata = r_wdata;
        unique case (1'b1)
            (w_size == SZ_B): begin
                w_be        = 4'b0001 << w_lane;
                w_ram_wdata = {4{r_wdata[7:0]}};
            end
            (w_size == SZ_H): begin
                w_be        = 4'b0011 << {w_lane[1], 1'b0};
                w_ram_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_ram_wdata = r_wdata;
            end
        endcase
        if (w_mis) begin
            w_be = 4'b0000;
        end
    end

    assign w_ram_be = ((r_state == DONE) && r_store && !RESET)
                    ? w_be : 4'b0000;

    assign w_ld_fire = !RESET && !w_cur_store &&
        ((w_start && !HAS_WAIT) ||
         ((r_state == WAIT) && (r_cnt == 4'd0)));

    dmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_re   (w_ld_fire),
        .i_be   (w_ram_be),
        .i_addr (w_cur_addr[AB-1:2]),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_q)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ld_lane <= '0;
            r_ld_f3   <= '0;
            r_ld_zero <= 1'b0;
        end else if (w_ld_fire) begin
            r_ld_lane <= w_lane;
            r_ld_f3   <= w_cur_f3;
            r_ld_zero <= w_mis;
        end
    end

    // Extraction works purely on registered state, so read_data holds
    // until the next load lands in the RAM output register.
    assign w_ld_size = f3_size(r_ld_f3);
    assign w_half    = r_ld_lane[1] ? w_q[31:16] : w_q[15:0];

    always_comb begin
        w_byte = w_q[7:0];
        unique case (r_ld_lane)
            2'd0:    w_byte = w_q[7:0];
            2'd1:    w_byte = w_q[15:8];
            2'd2:    w_byte = w_q[23:16];
            default: w_byte = w_q[31:24];
        endcase
    end

    always_comb begin
        w_ext = w_q;
        unique case (1'b1)
            (w_ld_size == SZ_B):
                w_ext = r_ld_f3[2] ? {24'd0, w_byte}
                                   : {{24{w_byte[7]}}, w_byte};
            (w_ld_size == SZ_H):
                w_ext = r_ld_f3[2] ? {16'd0, w_half}
                                   : {{16{w_half[15]}}, w_half};
            default: w_ext = w_q;
        endcase
    end

    assign read_data = r_ld_zero ? 32'd0 : w_ext;
    assign stall     = w_stall & ~RESET;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = (r_state == DONE) & w_mis & ~RESET;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench: instance A with one wait state, instance B with none.
// Expectations for misaligned cases follow DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_access_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    logic [31:0] rdata_a, rdata_b;
    logic        stall_a, stall_b, mis_a, mis_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_a  = 32'd0;
    logic [31:0] last_b  = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_access_unit #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut_a (
        .CLK(clk), .RESET(rst_a),
        .memory_read(rd_a), .memory_write(wr_a),
        .funct3(f3), .address(addr), .write_data(wd),
        .read_data(rdata_a), .stall(stall_a), .misaligned(mis_a)
    );

    data_mem_access_unit #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
        .CLK(clk), .RESET(rst_b),
        .memory_read(rd_b), .memory_write(wr_b),
        .funct3(f3), .address(addr), .write_data(wd),
        .read_data(rdata_b), .stall(stall_b), .misaligned(mis_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge of
    // the cycle after DONE, ready for a back-to-back request.
    task automatic access(input bit inst, input bit st,
                          input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_ld,
                          input bit exp_mis, input string tag);
        int ws     = inst ? 0 : 1;
        int stalls = 0;
        int start;
        f3   = f;
        addr = a;
        wd   = d;
        if (inst) begin
            rd_b = !st;
            wr_b = st;
        end else begin
            rd_a = !st;
            wr_a = st;
        end
        if (!st) exp_q.push_back(exp_ld);
        start = cyc;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (inst ? stall_b : stall_a) begin
                stalls++;
                @(negedge clk);
            end else begin
                break;
            end
        end
        check({tag, "_stall"}, 32'(stalls), 32'(ws + 1));
        check({tag, "_lat"}, 32'(cyc - start), 32'(ws + 1));
        check({tag, "_mis"}, 32'(inst ? mis_b : mis_a), 32'(exp_mis));
        if (!st) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb"}, 32'd0, 32'd1);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check(tag, inst ? rdata_b : rdata_a, e);
                if (inst) last_b = e;
                else      last_a = e;
            end
        end else begin
            check({tag, "_hold"}, inst ? rdata_b : rdata_a,
                  inst ? last_b : last_a);
        end
        @(negedge clk);
        rd_a = 1'b0; wr_a = 1'b0;
        rd_b = 1'b0; wr_b = 1'b0;
    endtask

    localparam bit TRAP =
`ifdef DMEM_MISALIGN_TRAP_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        f3 = F3_W; addr = '0; wd = '0;
        repeat (3) @(negedge clk);
        rd_a = 1'b1;
        #1;
        check("rst_stall", 32'(stall_a), 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_mis", 32'(mis_a), 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        @(negedge clk);
        rd_a = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        access(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 0, 0, "sw10");
        access(0, 0, F3_W,  32'h10, 0, 32'hDEADBEEF, 0, "lw10");
        access(0, 0, F3_B,  32'h13, 0, 32'hFFFFFFDE, 0, "lb13");
        access(0, 0, F3_BU, 32'h13, 0, 32'h000000DE, 0, "lbu13");
        access(0, 0, F3_H,  32'h10, 0, 32'hFFFFBEEF, 0, "lh10");
        access(0, 0, F3_HU, 32'h12, 0, 32'h0000DEAD, 0, "lhu12");
        access(0, 1, F3_B,  32'h11, 32'h00000055, 0, 0, "sb11");
        access(0, 0, F3_W,  32'h10, 0, 32'hDEAD55EF, 0, "lw10b");

        repeat (3) @(negedge clk);
        #1;
        check("idle_stall", 32'(stall_a), 32'd0);
        check("idle_hold", rdata_a, 32'hDEAD55EF);

        access(0, 1, F3_W, 32'h20, 32'hCAFEF00D, 0, 0, "sw20");
        access(0, 0, F3_W, 32'h20, 0, 32'hCAFEF00D, 0, "lw20");

        // Store aborted by reset in its WAIT cycle.
        f3 = F3_W; addr = 32'h20; wd = 32'h12345678; wr_a = 1'b1;
        @(negedge clk);
        #1;
        check("abort_wait_stall", 32'(stall_a), 32'd1);
        rst_a = 1'b1;
        wr_a = 1'b0;
        #1;
        check("abort_rst_stall", 32'(stall_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        last_a = 32'd0;
        #1;
        check("abort_idle_stall", 32'(stall_a), 32'd0);
        check("abort_rdata", rdata_a, 32'd0);
        access(0, 0, F3_W, 32'h20, 0, 32'hCAFEF00D, 0, "lw20_abort");

        access(0, 1, F3_W, 32'h22, 32'hA5A5A5A5, 0, TRAP, "sw22");
        access(0, 0, F3_W, 32'h20, 0,
               TRAP ? 32'hCAFEF00D : 32'hA5A5A5A5, 0, "lw20_mis");
        access(0, 0, F3_W, 32'h12, 0,
               TRAP ? 32'h0 : 32'hDEAD55EF, TRAP, "lw12");
        access(0, 0, F3_H, 32'h11, 0,
               TRAP ? 32'h0 : 32'h000055EF, TRAP, "lh11");

        access(1, 1, F3_W,  32'h40,   32'h01020304, 0, 0, "b_sw40");
        access(1, 0, F3_W,  32'h40,   0, 32'h01020304, 0, "b_lw40");
        access(1, 0, F3_W,  32'h1040, 0, 32'h01020304, 0, "b_wrap");
        access(1, 0, F3_H,  32'h42,   0, 32'h00000102, 0, "b_lh42");
        access(1, 0, F3_BU, 32'h43,   0, 32'h00000001, 0, "b_lbu43");
        access(1, 1, F3_H,  32'h42,   32'h0000F00F, 0, 0, "b_sh42");
        access(1, 0, F3_B,  32'h43,   0, 32'hFFFFFFF0, 0, "b_lb43");

        if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
